// File: rtl/song_sequencer_pkg.sv
// ============================================================================
// song_sequencer_pkg : shared state and end-of-song mode encodings
// Rev 1.0
// ============================================================================
`default_nettype none

package song_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_PLAY  = 2'd2,
        ST_PAUSE = 2'd3
    } state_t;

    localparam logic [1:0] MODE_SINGLE  = 2'd0;
    localparam logic [1:0] MODE_REPEAT  = 2'd1;
    localparam logic [1:0] MODE_ALL     = 2'd2;
    localparam logic [1:0] MODE_SHUFFLE = 2'd3;

endpackage

`default_nettype wire

// File: rtl/song_sequencer_if.sv
// ============================================================================
// song_sequencer_if : control/status bundle between keypad side and sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

interface song_sequencer_if #(
    parameter int SONG_W = 4
) ();
    logic              step_en;
    logic              song_req_valid;
    logic [SONG_W-1:0] song_req;
    logic [1:0]        mode;
    logic              pause_toggle;
    logic              stop;
    logic              song_done;
    logic              play;
    logic              reset_player;
    logic [SONG_W-1:0] song;
    logic              req_err;
    logic              busy;

    modport master (
        output step_en, song_req_valid, song_req, mode, pause_toggle, stop, song_done,
        input  play, reset_player, song, req_err, busy
    );

    modport slave (
        input  step_en, song_req_valid, song_req, mode, pause_toggle, stop, song_done,
        output play, reset_player, song, req_err, busy
    );
endinterface

`default_nettype wire

// File: rtl/song_sequencer_lfsr16.sv
// ============================================================================
// lfsr16 : 16-bit Fibonacci LFSR, taps x^16+x^14+x^13+x^11+1
// Rev 1.0
// ============================================================================
`default_nettype none

module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  wire         clk,
    input  wire         rst_n,
    input  wire         en,
    output logic [15:0] q
);
    logic [15:0] r_q;
    logic        w_fb;

    assign w_fb = r_q[15] ^ r_q[13] ^ r_q[12] ^ r_q[10];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= SEED;
        end else if (en) begin
            r_q <= {r_q[14:0], w_fb};
        end
    end

    assign q = r_q;
endmodule

`default_nettype wire

// File: rtl/song_sequencer.sv
// ============================================================================
// song_sequencer : song selection FSM with end-of-song modes, pause and stop
// Rev 1.0
// ============================================================================
`default_nettype none

module song_sequencer
    import song_sequencer_pkg::*;
#(
    parameter int          SONG_W    = 4,
    parameter int          NUM_SONGS = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  wire             clk,
    input  wire             rst_n,
    song_sequencer_if.slave bus
);
    state_t            r_state, w_state_nxt;
    logic [SONG_W-1:0] r_song, w_song_nxt;
    logic [SONG_W-1:0] r_pend_song, w_req_song, w_succ, w_cand, w_shuf;
    logic              r_pend_valid, r_req_err;
    logic              w_req_ok, w_req_any;
    logic [15:0]       w_lfsr;
    logic              w_lfsr_unused;

    // Free-running so shuffle order depends on request timing.
    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .q     (w_lfsr)
    );

    assign w_lfsr_unused = ^w_lfsr;

    assign w_req_ok   = bus.song_req_valid && (32'(bus.song_req) < NUM_SONGS);
    assign w_req_any  = w_req_ok || r_pend_valid;
    assign w_req_song = w_req_ok ? bus.song_req : r_pend_song;

    assign w_succ = (32'(r_song) == NUM_SONGS - 1) ? '0 : r_song + SONG_W'(1);
    assign w_cand = w_lfsr[SONG_W-1:0];
    assign w_shuf = ((32'(w_cand) >= NUM_SONGS) || (w_cand == r_song)) ? w_succ : w_cand;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_song  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_song  <= w_song_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_song_nxt  = r_song;
        if (bus.step_en) begin
            if (bus.stop) begin
                w_state_nxt = ST_IDLE;
            end else if (w_req_any) begin
                w_state_nxt = ST_LOAD;
                w_song_nxt  = w_req_song;
            end else begin
                case (r_state)
                    ST_IDLE:  w_state_nxt = ST_IDLE;
                    ST_LOAD:  w_state_nxt = ST_PLAY;
                    ST_PLAY: begin
                        if (bus.song_done) begin
                            case (bus.mode)
                                MODE_SINGLE:  w_state_nxt = ST_IDLE;
                                MODE_REPEAT:  w_state_nxt = ST_LOAD;
                                MODE_ALL: begin
                                    w_state_nxt = ST_LOAD;
                                    w_song_nxt  = w_succ;
                                end
                                MODE_SHUFFLE: begin
                                    w_state_nxt = ST_LOAD;
                                    w_song_nxt  = w_shuf;
                                end
                                default:      w_state_nxt = ST_IDLE;
                            endcase
                        end else if (bus.pause_toggle) begin
                            w_state_nxt = ST_PAUSE;
                        end
                    end
                    ST_PAUSE: begin
                        if (bus.pause_toggle) begin
                            w_state_nxt = ST_PLAY;
                        end
                    end
                    default:  w_state_nxt = ST_IDLE;
                endcase
            end
        end
    end

    // Every step_en cycle consumes (or, under stop, discards) the pending request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_valid <= 1'b0;
            r_pend_song  <= '0;
            r_req_err    <= 1'b0;
        end else begin
            r_req_err <= bus.song_req_valid && !w_req_ok;
            if (bus.step_en) begin
                r_pend_valid <= 1'b0;
            end else if (w_req_ok) begin
                r_pend_valid <= 1'b1;
                r_pend_song  <= bus.song_req;
            end
        end
    end

    assign bus.play         = (r_state == ST_PLAY);
    assign bus.reset_player = (r_state == ST_LOAD);
    assign bus.busy         = (r_state != ST_IDLE);
    assign bus.song         = r_song;
    assign bus.req_err      = r_req_err;
endmodule

`default_nettype wire

// File: tb/tb_song_sequencer.sv
// ============================================================================
// tb_song_sequencer : scoreboard bench with a behavioural model of the sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_song_sequencer;
    localparam int          SW   = 5;
    localparam int          NS   = 16;
    localparam logic [15:0] SEED = 16'hACE1;

    localparam int S_IDLE  = 0;
    localparam int S_LOAD  = 1;
    localparam int S_PLAY  = 2;
    localparam int S_PAUSE = 3;

    typedef struct packed {
        logic          play;
        logic          rp;
        logic [SW-1:0] song;
        logic          err;
        logic          busy;
    } obs_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    song_sequencer_if #(.SONG_W(SW)) sif ();

    song_sequencer #(
        .SONG_W    (SW),
        .NUM_SONGS (NS),
        .LFSR_SEED (SEED)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    obs_t q_exp[$];

    int          m_st;
    int          m_song;
    bit          m_pend;
    int          m_pend_song;
    logic [15:0] m_lfsr;

    task automatic check_obs(input string name, input obs_t e);
        obs_t got;
        got = {sif.play, sif.reset_player, sif.song, sif.req_err, sif.busy};
        n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL %s t=%0t got play=%b rp=%b song=%0d err=%b busy=%b, want play=%b rp=%b song=%0d err=%b busy=%b",
                     name, $time, got.play, got.rp, got.song, got.err, got.busy,
                     e.play, e.rp, e.song, e.err, e.busy);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (q_exp.size() > 0) check_obs("out", q_exp.pop_front());
    end

    task automatic model_reset();
        m_st        = S_IDLE;
        m_song      = 0;
        m_pend      = 0;
        m_pend_song = 0;
        m_lfsr      = SEED;
    endtask

    // Expected outputs after the coming clock edge, given this cycle's inputs.
    task automatic model_step(input bit se, input bit rv, input int rq, input int md,
                              input bit pt, input bit sp, input bit sd);
        bit   ok, req;
        int   rs, succ, cand;
        obs_t e;
        ok   = rv && (rq < NS);
        succ = (m_song + 1) % NS;
        if (se) begin
            req    = ok || m_pend;
            rs     = ok ? rq : m_pend_song;
            m_pend = 0;
            if (sp) m_st = S_IDLE;
            else if (req) begin
                m_st   = S_LOAD;
                m_song = rs;
            end else if (m_st == S_LOAD) m_st = S_PLAY;
            else if (m_st == S_PLAY && sd) begin
                case (md)
                    0: m_st = S_IDLE;
                    1: m_st = S_LOAD;
                    2: begin m_st = S_LOAD; m_song = succ; end
                    default: begin
                        cand   = int'(m_lfsr) % (1 << SW);
                        m_st   = S_LOAD;
                        m_song = (cand >= NS || cand == m_song) ? succ : cand;
                    end
                endcase
            end else if (m_st == S_PLAY && pt) m_st = S_PAUSE;
            else if (m_st == S_PAUSE && pt) m_st = S_PLAY;
        end else if (ok) begin
            m_pend      = 1;
            m_pend_song = rq;
        end
        m_lfsr = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
        e.play = (m_st == S_PLAY);
        e.rp   = (m_st == S_LOAD);
        e.song = SW'(m_song);
        e.err  = rv && !ok;
        e.busy = (m_st != S_IDLE);
        q_exp.push_back(e);
    endtask

    task automatic drive(input bit se, input bit rv, input int rq, input int md,
                         input bit pt, input bit sp, input bit sd);
        sif.step_en        = se;
        sif.song_req_valid = rv;
        sif.song_req       = SW'(rq);
        sif.mode           = 2'(md);
        sif.pause_toggle   = pt;
        sif.stop           = sp;
        sif.song_done      = sd;
    endtask

    task automatic tick(input bit se, input bit rv, input int rq, input int md,
                        input bit pt, input bit sp, input bit sd);
        @(negedge clk);
        drive(se, rv, rq, md, pt, sp, sd);
        model_step(se, rv, rq, md, pt, sp, sd);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 0);
        model_step(1, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #12;
        check_obs("reset_state", '0);
        release_reset();

        // request 5: LOAD next cycle, PLAY the one after
        tick(1, 1, 5, 2, 0, 0, 0);
        tick(1, 0, 0, 2, 0, 0, 0);

        // play-all wrap from the last song
        tick(1, 1, 15, 2, 0, 0, 0);
        tick(1, 0, 0, 2, 0, 0, 0);
        tick(1, 0, 0, 2, 0, 0, 1);
        tick(1, 0, 0, 2, 0, 0, 0);

        // buffered requests while step_en is low; newest wins
        tick(0, 1, 3, 2, 0, 0, 0);
        tick(0, 1, 7, 2, 0, 0, 0);
        repeat (4) tick(0, 0, 0, 2, 0, 0, 0);
        tick(1, 0, 0, 2, 0, 0, 0);
        tick(1, 0, 0, 2, 0, 0, 0);
        tick(1, 0, 0, 2, 0, 0, 0);
        tick(1, 1, 20, 2, 0, 0, 0);
        tick(1, 0, 0, 2, 0, 0, 0);

        // request beats song_done; stop beats request
        tick(1, 1, 9, 1, 0, 0, 1);
        tick(1, 0, 0, 1, 0, 0, 0);
        tick(1, 1, 4, 1, 0, 1, 0);
        tick(1, 0, 0, 1, 0, 0, 0);

        // pause / resume, song_done ignored while paused
        tick(1, 1, 2, 1, 0, 0, 0);
        tick(1, 0, 0, 1, 0, 0, 0);
        tick(1, 0, 0, 1, 1, 0, 0);
        tick(1, 0, 0, 1, 0, 0, 1);
        tick(1, 0, 0, 1, 1, 0, 0);
        tick(1, 0, 0, 1, 0, 0, 0);
        tick(1, 0, 0, 1, 0, 0, 1);
        tick(1, 0, 0, 1, 0, 0, 0);

        // single mode ends in IDLE
        tick(1, 0, 0, 0, 0, 0, 1);
        tick(1, 0, 0, 0, 0, 0, 0);

        // shuffle run
        tick(1, 1, 1, 3, 0, 0, 0);
        tick(1, 0, 0, 3, 0, 0, 0);
        for (int i = 0; i < 200; i++) begin
            tick(1, 0, 0, 3, 0, 0, 1);
            tick(1, 0, 0, 3, 0, 0, 0);
        end

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                 int'($urandom_range(0, 31)), int'($urandom_range(0, 3)),
                 $urandom_range(0, 11) == 0, $urandom_range(0, 59) == 0,
                 $urandom_range(0, 4) == 0);
        end

        // asynchronous reset in the middle of LOAD
        tick(1, 1, 6, 2, 0, 0, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_obs("async_reset", '0);
        model_reset();
        repeat (3) @(negedge clk);
        release_reset();
        tick(1, 1, 11, 2, 0, 0, 0);
        tick(1, 0, 0, 2, 0, 0, 0);

        repeat (3) @(negedge clk);
        n_checks++;
        if (q_exp.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d want 0", q_exp.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
